sens_hispi_dly_seq: RTL and testbench

//  Command sequencer for the HiSPi receiver's mclk-domain delay/phase controls: lane IDELAY, load strobe, clock phase, MMCM reset.

---
 rtl/sens_hispi_dly_seq.sv | 142 ++++++++++++++
 tb/tb_sens_hispi_dly_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sens_hispi_dly_seq.sv
// sens_hispi_dly_seq: queued sequencer for HiSPi lane delay, idelay load, clock phase and MMCM reset
module sens_hispi_dly_seq #(
  parameter int HISPI_NUMLANES  = 4,
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int RST_CYCLES      = 8,
  parameter int PS_TIMEOUT      = 1024,
  parameter int LOCK_TIMEOUT    = 4095
) (
  input  logic                          mclk,
  input  logic                          mrst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [1:0]                    cmd_lane,
  input  logic [7:0]                    cmd_data,
  output logic [8*HISPI_NUMLANES-1:0]   dly_data,
  output logic [HISPI_NUMLANES-1:0]     set_idelay,
  output logic                          ld_idelay,
  output logic                          set_clk_phase,
  output logic                          rst_mmcm,
  input  logic                          ps_rdy,
  input  logic                          locked_pxd_mmcm,
  input  logic                          err_clr,
  output logic                          busy,
  output logic                          done,
  output logic                          err_timeout,
  output logic                          err_lane
);
  localparam int N = HISPI_NUMLANES;
  localparam int L = FIFO_DEPTH_LOG2;
  localparam int FW = L + 1;
  localparam int MX0 = PS_TIMEOUT > LOCK_TIMEOUT ? PS_TIMEOUT : LOCK_TIMEOUT;
  localparam int MX = MX0 > RST_CYCLES ? MX0 : RST_CYCLES;
  localparam int CW = $clog2(MX + 1);
  localparam logic [2:0] NL = 3'(N);
  localparam logic [FW-1:0] FULL = {1'b1, {L{1'b0}}};
  localparam logic [CW-1:0] PS_END = CW'(PS_TIMEOUT);
  localparam logic [CW-1:0] LK_END = CW'(LOCK_TIMEOUT);
  localparam logic [CW-1:0] RS_END = CW'(RST_CYCLES);
  typedef enum logic [2:0] {IDLE, HOLD, PS_LO, PS_HI, RST, LOCK} state_t;
  state_t state;
  logic [11:0] mem [1<<L];
  logic [L-1:0] wp, rp;
  logic [FW-1:0] cnt_f;
  logic rdy_r, push, pop, lane_ok;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0] h_op, h_lane;
  logic [7:0] h_data;
  logic [3:0] oh;
  assign cmd_ready = rdy_r & (cnt_f != FULL);
  assign push = cmd_valid & cmd_ready;
  assign pop = (state == IDLE) & (cnt_f != '0);
  assign {h_op, h_lane, h_data} = mem[rp];
  assign oh = 4'b1 << h_lane;
  assign lane_ok = {1'b0, h_lane} < NL;
  assign cnt_nx = cnt + CW'(1);
  assign busy = (cnt_f != '0) | ((state != IDLE) & ~done);
  always_ff @(posedge mclk) begin
    if (push) mem[wp] <= {cmd_op, cmd_lane, cmd_data};
  end
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      cnt_f <= '0;
      rdy_r <= 1'b0;
      cnt <= '0;
      dly_data <= '0;
      set_idelay <= '0;
      ld_idelay <= 1'b0;
      set_clk_phase <= 1'b0;
      rst_mmcm <= 1'b0;
      done <= 1'b0;
      err_timeout <= 1'b0;
      err_lane <= 1'b0;
    end else begin
      rdy_r <= 1'b1;
      if (push) wp <= wp + L'(1);
      if (pop) rp <= rp + L'(1);
      cnt_f <= cnt_f + FW'(push) - FW'(pop);
      set_idelay <= '0;
      ld_idelay <= 1'b0;
      set_clk_phase <= 1'b0;
      done <= 1'b0;
      err_timeout <= err_timeout & ~err_clr;
      err_lane <= err_lane & ~err_clr;
      cnt <= cnt_nx;
      case (state)
        IDLE: if (pop) begin
          cnt <= '0;
          state <= HOLD;
          case (h_op)
            2'd0: begin
              done <= 1'b1;
              if (lane_ok) begin
                set_idelay <= oh[N-1:0];
                for (int i = 0; i < N; i++) if (oh[i]) dly_data[8*i +: 8] <= h_data;
              end else err_lane <= 1'b1;
            end
            2'd1: begin
              ld_idelay <= 1'b1;
              done <= 1'b1;
            end
            2'd2: begin
              dly_data[7:0] <= h_data;
              set_clk_phase <= 1'b1;
              state <= PS_LO;
            end
            default: begin
              rst_mmcm <= 1'b1;
              state <= RST;
            end
          endcase
        end
        HOLD: state <= IDLE;
        PS_LO: if (!ps_rdy) state <= PS_HI;
        else if (cnt_nx == PS_END) begin
          done <= 1'b1;
          err_timeout <= 1'b1;
          state <= IDLE;
        end
        PS_HI: if (ps_rdy || cnt_nx == PS_END) begin
          done <= 1'b1;
          if (!ps_rdy) err_timeout <= 1'b1;
          state <= IDLE;
        end
        RST: if (cnt_nx == RS_END) begin
          rst_mmcm <= 1'b0;
          cnt <= '0;
          state <= LOCK;
        end
        LOCK: if (locked_pxd_mmcm || cnt_nx == LK_END) begin
          done <= 1'b1;
          if (!locked_pxd_mmcm) err_timeout <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sens_hispi_dly_seq.sv
// tb_sens_hispi_dly_seq: randomized scoreboard bench for sens_hispi_dly_seq
module tb_sens_hispi_dly_seq;
  localparam int N = 4;
  localparam int PST = 1024;
  localparam int LKT = 4095;
  localparam int RC = 8;
  logic mclk = 1'b0, mrst_n = 1'b0;
  logic cmd_valid = 1'b0, ps_rdy = 1'b1, locked = 1'b0, err_clr = 1'b0;
  logic [1:0] cmd_op = '0, cmd_lane = '0;
  logic [7:0] cmd_data = '0;
  logic cmd_ready, ld_idelay, set_clk_phase, rst_mmcm, busy, done, err_timeout, err_lane;
  logic [31:0] dly_data;
  logic [3:0] set_idelay;
  logic b_valid = 1'b0, b_clr = 1'b0, b_ps = 1'b1, b_lk = 1'b0;
  logic [1:0] b_op = '0, b_lane = '0;
  logic [7:0] b_data = '0;
  logic b_ready, b_ld, b_ph, b_rst, b_busy, b_done, b_et, b_el;
  logic [15:0] b_dly;
  logic [1:0] b_set;
  sens_hispi_dly_seq dut (
    .mclk(mclk), .mrst_n(mrst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_lane(cmd_lane), .cmd_data(cmd_data), .dly_data(dly_data),
    .set_idelay(set_idelay), .ld_idelay(ld_idelay), .set_clk_phase(set_clk_phase),
    .rst_mmcm(rst_mmcm), .ps_rdy(ps_rdy), .locked_pxd_mmcm(locked), .err_clr(err_clr),
    .busy(busy), .done(done), .err_timeout(err_timeout), .err_lane(err_lane)
  );
  sens_hispi_dly_seq #(.HISPI_NUMLANES(2)) dut2 (
    .mclk(mclk), .mrst_n(mrst_n), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_op(b_op), .cmd_lane(b_lane), .cmd_data(b_data), .dly_data(b_dly),
    .set_idelay(b_set), .ld_idelay(b_ld), .set_clk_phase(b_ph),
    .rst_mmcm(b_rst), .ps_rdy(b_ps), .locked_pxd_mmcm(b_lk), .err_clr(b_clr),
    .busy(b_busy), .done(b_done), .err_timeout(b_et), .err_lane(b_el)
  );
  always #5 mclk = ~mclk;
  typedef struct {
    logic [31:0] dly;
    logic el;
    logic et;
    logic [5:0] strb;
    int lat;
    int rlen;
  } exp_t;
  exp_t sb[$];
  int ps_plan[$], lk_plan[$];
  logic [7:0] m_dly [4];
  logic m_el = 1'b0, m_et = 1'b0;
  int checks = 0, errors = 0, cyc = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic issue(input logic [1:0] op, input logic [1:0] lane, input logic [7:0] data, input int plan);
    exp_t e;
    int w = 0;
    @(negedge mclk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_lane = lane;
    cmd_data = data;
    while (!cmd_ready && w < 5000) begin
      @(negedge mclk);
      w++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_wait: cmd_ready stuck at 0 for %0d cycles, required 1", w);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge mclk);
    e.strb = '0;
    e.lat = 0;
    e.rlen = 0;
    case (op)
      2'd0: if (int'(lane) < N) begin
        m_dly[lane] = data;
        e.strb = 6'b1 << lane;
      end else begin
        m_el = 1'b1;
        e.lat = -1;
      end
      2'd1: e.strb = 6'b010000;
      2'd2: begin
        m_dly[0] = data;
        e.strb = 6'b100000;
        e.lat = plan > 0 ? plan + 1 : PST;
        if (plan <= 0) m_et = 1'b1;
        ps_plan.push_back(plan);
      end
      default: begin
        e.rlen = RC;
        e.lat = plan >= 0 ? plan + 1 : LKT;
        if (plan < 0) m_et = 1'b1;
        lk_plan.push_back(plan);
      end
    endcase
    e.dly = {m_dly[3], m_dly[2], m_dly[1], m_dly[0]};
    e.el = m_el;
    e.et = m_et;
    sb.push_back(e);
    #1 cmd_valid = 1'b0;
  endtask
  task automatic drain(input int budget);
    int w = 0;
    while ((busy || sb.size() != 0) && w < budget) begin
      @(negedge mclk);
      w++;
    end
    chk("drain_busy", 32'(busy), 0);
    chk("drain_pending", 32'(sb.size()), 0);
  endtask
  task automatic b_issue(input logic [1:0] lane, input logic [7:0] data);
    int w = 0;
    @(negedge mclk);
    b_valid = 1'b1;
    b_lane = lane;
    b_data = data;
    while (!b_ready && w < 50) begin
      @(negedge mclk);
      w++;
    end
    chk("b_ready", 32'(b_ready), 1);
    @(posedge mclk);
    #1 b_valid = 1'b0;
  endtask
  logic [5:0] m_acc = '0, m_s;
  int m_rl = 0, m_tref = 0;
  logic m_prev = 1'b0;
  exp_t m_e;
  initial forever begin
    @(negedge mclk);
    cyc++;
    if (!mrst_n) begin
      m_acc = '0;
      m_rl = 0;
      m_prev = 1'b0;
    end else begin
      m_s = {set_clk_phase, ld_idelay, set_idelay};
      if (m_s != '0) begin
        chk("one_strobe", 32'($countones(m_s) <= 1), 1);
        m_tref = cyc;
      end
      m_acc |= m_s;
      if (rst_mmcm) m_rl++;
      if (m_prev && !rst_mmcm) m_tref = cyc;
      m_prev = rst_mmcm;
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=1 with nothing outstanding");
        end else begin
          m_e = sb.pop_front();
          chk("dly_data", dly_data, m_e.dly);
          chk("err_lane", 32'(err_lane), 32'(m_e.el));
          chk("err_timeout", 32'(err_timeout), 32'(m_e.et));
          chk("strobes", 32'(m_acc), 32'(m_e.strb));
          chk("rst_len", m_rl, m_e.rlen);
          if (m_e.lat >= 0) chk("latency", cyc - m_tref, m_e.lat);
          chk("busy_at_done", 32'(busy), 32'(sb.size() != 0));
        end
        m_acc = '0;
        m_rl = 0;
      end
    end
  end
  int ps_lo = 0, ps_p;
  initial forever begin
    @(negedge mclk);
    if (mrst_n && set_clk_phase) begin
      ps_p = ps_plan.size() != 0 ? ps_plan.pop_front() : 0;
      if (ps_p > 0) begin
        ps_rdy = 1'b0;
        ps_lo = ps_p;
      end
    end else if (ps_lo > 0) begin
      ps_lo--;
      if (ps_lo == 0) ps_rdy = 1'b1;
    end
  end
  int lk_p = -1, lk_cnt = 0;
  logic lk_in = 1'b0;
  initial forever begin
    @(negedge mclk);
    if (!mrst_n) begin
      lk_in = 1'b0;
      lk_cnt = 0;
    end else if (rst_mmcm && !lk_in) begin
      lk_in = 1'b1;
      lk_p = lk_plan.size() != 0 ? lk_plan.pop_front() : -1;
      locked = (lk_p == 0);
      lk_cnt = 0;
    end else if (!rst_mmcm && lk_in) begin
      lk_in = 1'b0;
      if (lk_p > 0) lk_cnt = lk_p;
    end else if (lk_cnt > 0) begin
      lk_cnt--;
      if (lk_cnt == 0) locked = 1'b1;
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end
  initial begin
    int w;
    logic [1:0] op;
    for (int i = 0; i < 4; i++) m_dly[i] = '0;
    repeat (3) @(negedge mclk);
    chk("rst_ready", 32'(cmd_ready), 0);
    chk("rst_outputs", {dly_data[15:0], set_idelay, ld_idelay, set_clk_phase, rst_mmcm, busy, done, err_timeout, err_lane}, 0);
    mrst_n = 1'b1;
    @(negedge mclk);
    chk("post_rst_ready", 32'(cmd_ready), 1);
    chk("post_rst_dly", dly_data, 0);
    chk("post_rst_flags", {set_idelay, ld_idelay, set_clk_phase, rst_mmcm, busy, done, err_timeout, err_lane}, 0);
    issue(2'd0, 2'd2, 8'h5A, 0);
    @(negedge mclk);
    chk("t1_no_strobe_yet", 32'(set_idelay), 0);
    chk("t1_busy", 32'(busy), 1);
    @(negedge mclk);
    chk("t1_strobe", 32'(set_idelay), 32'h4);
    chk("t1_done", 32'(done), 1);
    chk("t1_dly", dly_data, 32'h005A_0000);
    drain(50);
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      issue(op, 2'($urandom_range(0, 3)), 8'($urandom),
            op == 2'd2 ? int'($urandom_range(3, 40)) : int'($urandom_range(0, 30)));
      repeat ($urandom_range(0, 3)) @(negedge mclk);
    end
    drain(8000);
    b_issue(2'd1, 8'hC3);
    @(negedge mclk);
    @(negedge mclk);
    chk("b_strobe", 32'(b_set), 32'h2);
    chk("b_done", 32'(b_done), 1);
    chk("b_dly", 32'(b_dly), 32'hC300);
    b_issue(2'd3, 8'h77);
    @(negedge mclk);
    @(negedge mclk);
    chk("b_bad_no_strobe", 32'(b_set), 0);
    chk("b_bad_done", 32'(b_done), 1);
    chk("b_err_lane", 32'(b_el), 1);
    chk("b_dly_hold", 32'(b_dly), 32'hC300);
    @(negedge mclk);
    b_clr = 1'b1;
    @(negedge mclk);
    b_clr = 1'b0;
    chk("b_err_cleared", 32'(b_el), 0);
    b_issue(2'd2, 8'h11);
    b_clr = 1'b1;
    @(posedge mclk);
    #1 b_clr = 1'b0;
    @(negedge mclk);
    chk("b_set_wins_done", 32'(b_done), 1);
    chk("b_set_wins", 32'(b_el), 1);
    issue(2'd2, 2'd0, 8'h10, 0);
    for (int i = 0; i < 4; i++) issue(2'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), 0);
    @(negedge mclk);
    chk("full_ready", 32'(cmd_ready), 0);
    chk("full_busy", 32'(busy), 1);
    drain(3000);
    chk("t2_err_timeout", 32'(err_timeout), 32'(m_et));
    err_clr = 1'b1;
    @(negedge mclk);
    err_clr = 1'b0;
    m_et = 1'b0;
    chk("t2_err_cleared", 32'(err_timeout), 0);
    issue(2'd2, 2'd0, 8'h33, int'($urandom_range(3, 40)));
    drain(200);
    chk("t3_phase", 32'(dly_data[7:0]), 32'h33);
    chk("t3_no_timeout", 32'(err_timeout), 0);
    issue(2'd3, 2'd0, 8'h00, 0);
    issue(2'd3, 2'd0, 8'h00, -1);
    drain(9000);
    chk("t4_err_timeout", 32'(err_timeout), 1);
    err_clr = 1'b1;
    @(negedge mclk);
    err_clr = 1'b0;
    m_et = 1'b0;
    issue(2'd3, 2'd0, 8'h00, 0);
    w = 0;
    while (!rst_mmcm && w < 20) begin
      @(negedge mclk);
      w++;
    end
    chk("t6_rst_seen", 32'(rst_mmcm), 1);
    repeat (2) @(negedge mclk);
    #2 mrst_n = 1'b0;
    #1;
    chk("t6_rst_mmcm_drop", 32'(rst_mmcm), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_ready", 32'(cmd_ready), 0);
    sb.delete();
    ps_plan.delete();
    lk_plan.delete();
    for (int i = 0; i < 4; i++) m_dly[i] = '0;
    m_el = 1'b0;
    m_et = 1'b0;
    locked = 1'b0;
    repeat (2) @(negedge mclk);
    mrst_n = 1'b1;
    @(negedge mclk);
    chk("t6_ready_after", 32'(cmd_ready), 1);
    chk("t6_idle_after", {busy, rst_mmcm, done, dly_data[7:0]}, 0);
    issue(2'd0, 2'd1, 8'hA5, 0);
    drain(50);
    chk("t6_lane_dly", dly_data, 32'h0000_A500);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
